// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for four requesters feeding a one-entry registered output stage
// with a valid/ready handshake. Define MUX4_ARB_LOCK_EN to add the lock[3:0] burst-hold input.
module mux4_rr_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic [WIDTH-1:0] din3,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef MUX4_ARB_LOCK_EN
  ,
  input  logic [3:0]       lock
`endif
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_ptr;
  logic [1:0]       r_sel;
  logic [WIDTH-1:0] r_data;

  logic             w_load;
  logic [1:0]       w_c1;
  logic [1:0]       w_c2;
  logic [1:0]       w_c3;
  logic [1:0]       w_rr_win;
  logic [1:0]       w_win;
  logic [WIDTH-1:0] w_din;

  assign w_load = (|req) && ((r_state == ST_EMPTY) || out_ready);

  // Rotated priority: search starts just after the last winner; r_ptr itself is the
  // last candidate and is chosen only when nothing else requests.
  assign w_c1     = r_ptr + 2'd1;
  assign w_c2     = r_ptr + 2'd2;
  assign w_c3     = r_ptr + 2'd3;
  assign w_rr_win = req[w_c1] ? w_c1 :
                    req[w_c2] ? w_c2 :
                    req[w_c3] ? w_c3 : r_ptr;

`ifdef MUX4_ARB_LOCK_EN
  // A locked requester that owns the held word keeps the path for its next beat.
  assign w_win = ((r_state == ST_FULL) && req[r_sel] && lock[r_sel]) ? r_sel : w_rr_win;
`else
  assign w_win = w_rr_win;
`endif

  // Data select for the winning requester.
  always_comb begin
    w_din = din0;
    case (w_win)
      2'd0:    w_din = din0;
      2'd1:    w_din = din1;
      2'd2:    w_din = din2;
      2'd3:    w_din = din3;
      default: w_din = din0;
    endcase
  end

  // State register plus the captured word, its source index and the priority pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_data  <= {WIDTH{1'b0}};
      r_sel   <= 2'd0;
      r_ptr   <= 2'd3;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_data <= w_din;
        r_sel  <= w_win;
        r_ptr  <= w_win;
      end else begin
        r_data <= r_data;
        r_sel  <= r_sel;
        r_ptr  <= r_ptr;
      end
    end
  end

  // Next-state: a held word stays while the sink stalls or a new word replaces it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: w_state_nxt = w_load ? ST_FULL : ST_EMPTY;
      ST_FULL:  w_state_nxt = (out_ready && !(|req)) ? ST_EMPTY : ST_FULL;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  // Grant is combinational and forced low while reset is asserted.
  always_comb begin
    gnt = 4'b0000;
    if (rst_n && w_load) begin
      gnt = 4'b0001 << w_win;
    end else begin
      gnt = 4'b0000;
    end
  end

  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_data;
  assign sel       = r_sel;

endmodule
